// File: rtl/ec_pkg.sv
// Shared defaults, FSM state encoding and mask array type for the erasure-coding mask datapath.
package ec_pkg;
    localparam int K_MAX_DEF         = 128;
    localparam int M_MAX_DEF         = 128;
    localparam int K_MIN_DEF         = 2;
    localparam int M_MIN_DEF         = 2;
    localparam int W_DEF             = 4;
    localparam int PACKET_LENGTH_DEF = 2;
    localparam int NSW_DEF           = 16;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_IN,
        ISSUE,
        DONE
    } state_e;

    typedef logic [PACKET_LENGTH_DEF-1:0][0:W_DEF-1][0:K_MAX_DEF-1] mask_t;
endpackage

// File: rtl/mask_matrix_ram.sv
// Coding bit-matrix storage: one synchronous write port, one asynchronous read port, no reset.
module mask_matrix_ram #(
    parameter int DEPTH = 512,
    parameter int WIDTH = 512,
    parameter int AW    = 9
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/mask_scheduler.sv
// Steps each input stripe through all M*W parity bit-rows, presenting one registered mask
// pattern per row to mask_unit with a valid/ready handshake toward the XOR stage.
module mask_scheduler
    import ec_pkg::*;
#(
    parameter int K_MAX         = K_MAX_DEF,
    parameter int M_MAX         = M_MAX_DEF,
    parameter int K_MIN         = K_MIN_DEF,
    parameter int M_MIN         = M_MIN_DEF,
    parameter int W             = W_DEF,
    parameter int PACKET_LENGTH = PACKET_LENGTH_DEF,
    parameter int RAW           = $clog2(M_MAX*W),
    parameter int NSW           = NSW_DEF
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      cfg_we,
    input  logic [RAW-1:0]                            cfg_addr,
    input  logic [W*K_MAX-1:0]                        cfg_data,
    output logic                                      cfg_err,
    input  logic                                      start,
    input  logic [$clog2(K_MAX+1)-1:0]                k_cfg,
    input  logic [$clog2(M_MAX+1)-1:0]                m_cfg,
    input  logic [NSW-1:0]                            n_stripes,
    output logic                                      busy,
    output logic                                      done,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [PACKET_LENGTH-1:0][0:W-1][0:K_MAX-1] mask,
    output logic [RAW-1:0]                            out_row,
    output logic                                      out_last
);
    localparam int ROWS = M_MAX*W;
    localparam int BITS = W*K_MAX;

    state_e                     r_state, w_state_nxt;
    logic [$clog2(K_MAX+1)-1:0] r_k;
    logic [RAW-1:0]             r_last_row;
    logic [NSW-1:0]             r_n_last;
    logic [NSW-1:0]             r_stripe;
    logic                       r_cfg_err;
    logic                       r_out_valid;
    logic                       r_out_last;
    logic [RAW-1:0]             r_out_row;
    logic [BITS-1:0]            r_row_bits;

    logic            w_cfg_legal, w_addr_ok, w_wr_ok, w_start_ok, w_cfg_err_nxt;
    logic            w_hs, w_row_end, w_job_end, w_load, w_drop_valid;
    logic [RAW-1:0]  w_rd_addr;
    logic [BITS-1:0] w_rd_data, w_col_en;

    assign w_cfg_legal = (int'(k_cfg) >= K_MIN) && (int'(k_cfg) <= K_MAX) &&
                         (int'(m_cfg) >= M_MIN) && (int'(m_cfg) <= M_MAX) &&
                         (n_stripes != '0);
    assign w_addr_ok   = int'(cfg_addr) < ROWS;
    assign w_hs        = r_out_valid && out_ready;
    assign w_row_end   = w_hs && r_out_last;
    assign w_job_end   = w_row_end && (r_stripe == r_n_last);

    mask_matrix_ram #(
        .DEPTH (ROWS),
        .WIDTH (BITS),
        .AW    (RAW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_ok),
        .i_waddr (cfg_addr),
        .i_wdata (cfg_data),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A new row is read and registered on entry to a stripe and after every non-final handshake;
    // the last row of a non-final stripe chains straight into row 0 when the next stripe is present.
    always_comb begin
        w_state_nxt   = r_state;
        w_load        = 1'b0;
        w_drop_valid  = 1'b0;
        w_rd_addr     = '0;
        w_start_ok    = 1'b0;
        w_wr_ok       = 1'b0;
        w_cfg_err_nxt = cfg_we;
        case (r_state)
            IDLE: begin
                w_wr_ok       = cfg_we && w_addr_ok;
                w_cfg_err_nxt = (cfg_we && !w_addr_ok) || (start && !w_cfg_legal);
                if (start && w_cfg_legal) begin
                    w_start_ok  = 1'b1;
                    w_state_nxt = WAIT_IN;
                end
            end
            WAIT_IN: begin
                if (in_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (w_hs && !r_out_last) begin
                    w_load    = 1'b1;
                    w_rd_addr = r_out_row + RAW'(1);
                end else if (w_row_end) begin
                    if (w_job_end) begin
                        w_drop_valid = 1'b1;
                        w_state_nxt  = DONE;
                    end else if (in_valid) begin
                        w_load = 1'b1;
                    end else begin
                        w_drop_valid = 1'b1;
                        w_state_nxt  = WAIT_IN;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        for (int j = 0; j < K_MAX; j++) begin
            for (int i = 0; i < W; i++) begin
                w_col_en[j*W+i] = (j < int'(r_k));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cfg_err   <= 1'b0;
            r_k         <= '0;
            r_last_row  <= '0;
            r_n_last    <= '0;
            r_stripe    <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_row   <= '0;
            r_row_bits  <= '0;
        end else begin
            r_cfg_err <= w_cfg_err_nxt;
            if (w_start_ok) begin
                r_k        <= k_cfg;
                r_last_row <= RAW'(int'(m_cfg)*W - 1);
                r_n_last   <= n_stripes - NSW'(1);
                r_stripe   <= '0;
            end else if (w_row_end) begin
                r_stripe <= r_stripe + NSW'(1);
            end
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_row   <= w_rd_addr;
                r_out_last  <= (w_rd_addr == r_last_row);
                r_row_bits  <= w_rd_data & w_col_en;
            end else if (w_drop_valid) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    always_comb begin
        for (int b = 0; b < PACKET_LENGTH; b++) begin
            for (int i = 0; i < W; i++) begin
                for (int j = 0; j < K_MAX; j++) begin
                    mask[b][i][j] = r_row_bits[j*W+i];
                end
            end
        end
    end

    assign cfg_err   = r_cfg_err;
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign in_ready  = (r_state == ISSUE) && w_row_end;
    assign out_valid = r_out_valid;
    assign out_row   = r_out_row;
    assign out_last  = r_out_last;
endmodule

// File: tb/tb_mask_scheduler.sv
// Directed bench for mask_scheduler with a row-queue model of every expected parity-row transfer.
module tb_mask_scheduler;
    localparam int W     = 4;
    localparam int K_MAX = 4;
    localparam int M_MAX = 2;
    localparam int PL    = 2;
    localparam int RAW   = 3;
    localparam int NSW   = 16;

    logic                              clk = 1'b0;
    logic                              rst = 1'b1;
    logic                              cfg_we = 1'b0;
    logic [RAW-1:0]                    cfg_addr = '0;
    logic [W*K_MAX-1:0]                cfg_data = '0;
    logic                              cfg_err;
    logic                              start = 1'b0;
    logic [2:0]                        k_cfg = '0;
    logic [1:0]                        m_cfg = '0;
    logic [NSW-1:0]                    n_stripes = '0;
    logic                              busy, done;
    logic                              in_valid = 1'b0;
    logic                              in_ready;
    logic                              out_valid;
    logic                              out_ready = 1'b0;
    logic [PL-1:0][0:W-1][0:K_MAX-1]   mask;
    logic [RAW-1:0]                    out_row;
    logic                              out_last;

    mask_scheduler #(
        .K_MAX(K_MAX), .M_MAX(M_MAX), .W(W), .PACKET_LENGTH(PL), .NSW(NSW)
    ) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_err(cfg_err), .start(start), .k_cfg(k_cfg), .m_cfg(m_cfg), .n_stripes(n_stripes),
        .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .mask(mask), .out_row(out_row),
        .out_last(out_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  row;
        logic [15:0] data;
        logic        last;
        logic        job_end;
    } exp_t;

    exp_t        q[$];
    logic [15:0] shadow [8];
    int          checks = 0;
    int          errors = 0;
    int          n_rows = 0;
    int          n_inready = 0;
    int          n_done = 0;
    bit          mdl_on = 1'b0;
    bit          exp_done = 1'b0;

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: actual %h, required %h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic logic [31:0] flat_mask();
        logic [31:0] v;
        v = '0;
        for (int b = 0; b < PL; b++)
            for (int i = 0; i < W; i++)
                for (int j = 0; j < K_MAX; j++)
                    v[b*16 + j*W + i] = mask[b][i][j];
        return v;
    endfunction

    function automatic logic [7:0] col_bits(int j);
        logic [7:0] v;
        v = '0;
        for (int b = 0; b < PL; b++)
            for (int i = 0; i < W; i++)
                v[b*W + i] = mask[b][i][j];
        return v;
    endfunction

    function automatic logic [15:0] masked(logic [15:0] raw, int k);
        logic [15:0] r;
        r = raw;
        for (int j = 0; j < K_MAX; j++)
            if (j >= k) r[j*W +: W] = '0;
        return r;
    endfunction

    task automatic push_job(int k, int m, int n);
        exp_t e;
        for (int s = 0; s < n; s++) begin
            for (int r = 0; r < m*W; r++) begin
                e.row     = 3'(r);
                e.data    = masked(shadow[r], k);
                e.last    = (r == m*W-1);
                e.job_end = (s == n-1) && (r == m*W-1);
                q.push_back(e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_row(int a, logic [15:0] d);
        cfg_we = 1'b1; cfg_addr = 3'(a); cfg_data = d; shadow[a] = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic start_job(int k, int m, int n);
        start = 1'b1; k_cfg = 3'(k); m_cfg = 2'(m); n_stripes = 16'(n);
        push_job(k, m, n);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_job(int budget);
        int cyc;
        cyc = 0;
        while ((q.size() != 0 || busy) && cyc < budget) begin
            tick();
            cyc++;
        end
        chk("job_timeout", 32'(cyc < budget), 1);
    endtask

    // Per-cycle comparison of the DUT against the row queue.
    initial begin
        forever begin
            @(negedge clk);
            if (mdl_on) begin
                exp_t e;
                bit   hs_last;
                hs_last = 1'b0;
                if (exp_done) begin
                    chk("done_pulse", 32'(done), 1);
                    exp_done = 1'b0;
                end else begin
                    chk("done_quiet", 32'(done), 0);
                end
                if (out_valid) begin
                    chk("row_pending", 32'(q.size() != 0), 1);
                    if (q.size() != 0) begin
                        e = q[0];
                        chk("out_row", 32'(out_row), 32'(e.row));
                        chk("out_last", 32'(out_last), 32'(e.last));
                        chk("mask", flat_mask(), {e.data, e.data});
                        if (out_ready) begin
                            void'(q.pop_front());
                            n_rows++;
                            hs_last = e.last;
                            if (e.job_end) exp_done = 1'b1;
                        end
                    end
                end
                chk("in_ready", 32'(in_ready), 32'(hs_last));
                if (in_ready) n_inready++;
                if (done) n_done++;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, i0, d0;
        bit pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_cfg_err", 32'(cfg_err), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_out_row", 32'(out_row), 0);
        chk("rst_mask", flat_mask(), 0);
        rst = 1'b0;
        mdl_on = 1'b1;
        tick();

        // One-hot rows, full job
        for (int r = 0; r < 8; r++) write_row(r, 16'h0001 << r);
        in_valid = 1'b1; out_ready = 1'b1;
        r0 = n_rows; i0 = n_inready; d0 = n_done;
        start_job(4, 2, 1);
        chk("t2_busy", 32'(busy), 1);
        tick();
        chk("t2_row0_idx", 32'(out_row), 0);
        chk("t2_row0_mask", flat_mask(), 32'h0001_0001);
        wait_job(40);
        chk("t2_rows", 32'(n_rows - r0), 8);
        chk("t2_in_ready_pulses", 32'(n_inready - i0), 1);
        chk("t2_done_pulses", 32'(n_done - d0), 1);

        // Asynchronous reset in the middle of a stripe
        start_job(4, 2, 1);
        repeat (4) tick();
        chk("t1_at_row3", 32'(out_row), 3);
        mdl_on = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t1_rst_out_valid", 32'(out_valid), 0);
        chk("t1_rst_busy", 32'(busy), 0);
        chk("t1_rst_out_row", 32'(out_row), 0);
        q.delete();
        exp_done = 1'b0;
        tick();
        rst = 1'b0;
        mdl_on = 1'b1;
        r0 = n_rows; i0 = n_inready; d0 = n_done;
        start_job(4, 2, 1);
        wait_job(40);
        chk("t1_rerun_rows", 32'(n_rows - r0), 8);
        chk("t1_rerun_done", 32'(n_done - d0), 1);

        // k=2 column masking, last write coinciding with start
        for (int r = 0; r < 7; r++) write_row(r, 16'hFFFF);
        cfg_we = 1'b1; cfg_addr = 3'd7; cfg_data = 16'hFFFF; shadow[7] = 16'hFFFF;
        start_job(2, 2, 1);
        cfg_we = 1'b0;
        tick();
        chk("t3_col0", 32'(col_bits(0)), 32'hFF);
        chk("t3_col1", 32'(col_bits(1)), 32'hFF);
        chk("t3_col2", 32'(col_bits(2)), 32'h00);
        chk("t3_col3", 32'(col_bits(3)), 32'h00);
        wait_job(40);

        // Back-pressure pattern 1,0,0,1
        for (int r = 0; r < 8; r++) write_row(r, 16'hA5A5 ^ (16'h0001 << r));
        r0 = n_rows;
        start_job(4, 2, 1);
        for (int c = 0; c < 80 && (q.size() != 0 || busy); c++) begin
            out_ready = pat[c % 4];
            tick();
        end
        out_ready = 1'b1;
        chk("t4_drained", 32'(q.size()), 0);
        chk("t4_rows", 32'(n_rows - r0), 8);
        wait_job(10);

        // Three stripes, config write while busy
        for (int r = 0; r < 8; r++) write_row(r, 16'h0001 << r);
        r0 = n_rows; i0 = n_inready; d0 = n_done;
        start_job(3, 2, 3);
        repeat (4) tick();
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 16'hAAAA;
        tick();
        cfg_we = 1'b0;
        chk("t5_cfg_err_pulse", 32'(cfg_err), 1);
        tick();
        chk("t5_cfg_err_clear", 32'(cfg_err), 0);
        wait_job(100);
        chk("t5_rows", 32'(n_rows - r0), 24);
        chk("t5_in_ready_pulses", 32'(n_inready - i0), 3);
        chk("t5_done_pulses", 32'(n_done - d0), 1);
        start_job(4, 2, 1);
        tick();
        chk("t5_ram_unchanged", flat_mask(), 32'h0001_0001);
        wait_job(40);

        // Illegal configurations
        start = 1'b1; k_cfg = 3'd4; m_cfg = 2'd1; n_stripes = 16'd1;
        tick();
        start = 1'b0;
        chk("t6_m1_cfg_err", 32'(cfg_err), 1);
        chk("t6_m1_busy", 32'(busy), 0);
        tick();
        chk("t6_m1_still_idle", 32'(busy), 0);
        start = 1'b1; k_cfg = 3'd5; m_cfg = 2'd2; n_stripes = 16'd1;
        tick();
        start = 1'b0;
        chk("t6_k5_cfg_err", 32'(cfg_err), 1);
        chk("t6_k5_busy", 32'(busy), 0);
        tick();
        chk("t6_k5_still_idle", 32'(busy), 0);
        chk("t6_no_rows", 32'(out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
